// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receive path: prefix bytes,
// frame FSM state encodings and the event record pushed into the FIFO.
package ps2_pkg;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   // Event record, 10 bits: {ext, brk, code[7:0]}
   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_event_t;

endpackage

// File: rtl/ps2_fall_det.sv
// Plain synchronizer for kbclk/kbdata plus a one-cycle falling-edge pulse
// on the synchronized kbclk. No debouncing, so bit timing is not skewed.
module ps2_fall_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic kbclk,
   input  logic kbdata,
   output logic fall,
   output logic data
);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;

   // Shift both raw lines through the synchronizer chain; lines idle high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], kbclk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], kbdata};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
      end
   end

   assign fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
   assign data = data_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receive controller: frame assembly with parity/stop/timeout
// checks, E0/F0 prefix decoding and a first-word fall-through event FIFO.
//
// Event handshake: ev_valid is high whenever the FIFO head holds an event and
// ev_code/ev_ext/ev_break describe that head; the head is consumed on a clock
// edge where ev_valid && ev_ready. ev_valid never drops without a pop (except
// reset), and ev_* do not change while ev_valid is high and ev_ready is low.
module ps2_key_ctrl
   import ps2_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50000,
   parameter int FIFO_DEPTH     = 4,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       kbclk,
   input  logic       kbdata,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_break,
   output logic       frame_err,
   output logic       ovf,
   input  logic       ovf_clr,
   output logic [1:0] dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]   DFULL = (AW+1)'(FIFO_DEPTH);

   logic       fall;
   logic       sdata;
   ps2_state_t state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       par_bit;
   logic [TW-1:0] timer;
   logic       byte_ok;
   logic [7:0] byte_val;
   logic       ext_pend;
   logic       brk_pend;

   ps2_event_t        mem [FIFO_DEPTH];
   ps2_event_t        last_q;
   ps2_event_t        head;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              push_ev;
   logic              pop;
   logic              full;
   logic              wr_en;
   logic              drop;

   ps2_fall_det #(.SYNC_STAGES(SYNC_STAGES)) u_fall_det (
      .clk    (clk),
      .rst_n  (rst_n),
      .kbclk  (kbclk),
      .kbdata (kbdata),
      .fall   (fall),
      .data   (sdata)
   );

   assign dbg_state = state;

   // Frame FSM: bit assembly on kbclk falls, parity/stop check, inter-edge timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         timer     <= '0;
         byte_ok   <= 1'b0;
         byte_val  <= '0;
         frame_err <= 1'b0;
      end else begin
         byte_ok   <= 1'b0;
         frame_err <= 1'b0;
         if (state == ST_IDLE) begin
            // A fall with data high is a glitch, not a start bit
            if (fall && !sdata) begin
               state   <= ST_DATA;
               bit_cnt <= '0;
               timer   <= '0;
            end
         end else if (fall) begin
            // A fall outranks a timeout landing in the same cycle
            timer <= '0;
            case (state)
               ST_DATA: begin
                  shreg   <= {sdata, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_bit <= sdata;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  if ((^{shreg, par_bit}) && sdata) begin
                     byte_ok  <= 1'b1;
                     byte_val <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timer == TMAX) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
            shreg     <= '0;
            bit_cnt   <= '0;
            timer     <= '0;
         end else begin
            timer <= timer + TW'(1);
         end
      end
   end

   assign push_ev = byte_ok && (byte_val != PS2_PFX_EXT) && (byte_val != PS2_PFX_BRK);
   assign pop     = ev_valid && ev_ready;
   assign full    = (count == DFULL);
   assign wr_en   = push_ev && (!full || pop);
   assign drop    = push_ev && full && !pop;

   // Prefix decoder: remember E0/F0 until the next real scancode or an error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (frame_err) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (byte_ok) begin
         if (byte_val == PS2_PFX_EXT) begin
            ext_pend <= 1'b1;
         end else if (byte_val == PS2_PFX_BRK) begin
            brk_pend <= 1'b1;
         end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are don't-care while not counted, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= '{ext: ext_pend, brk: brk_pend, code: byte_val};
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         last_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop)         ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
      end
   end

   // Head view: live head while occupied, last popped event while empty.
   always_comb begin
      head = last_q;
      if (count != '0) head = mem[rd_ptr];
   end

   assign ev_valid = (count != '0);
   assign ev_code  = head.code;
   assign ev_ext   = head.ext;
   assign ev_break = head.brk;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: directed scenarios plus random frames, with a
// byte-level reference model of prefix decoding and FIFO capacity.
module tb_ps2_key_ctrl;

   localparam int T_CYC = 300;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       kbclk;
   logic       kbdata;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_break;
   logic       frame_err;
   logic       ovf;
   logic       ovf_clr;
   logic [1:0] dbg_state;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int fail_cnt = 0;

   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   int         got_base = 0;
   int         err_cnt  = 0;
   int         err_base = 0;
   int         exp_err  = 0;
   bit         ext_p    = 1'b0;
   bit         brk_p    = 1'b0;

   ps2_key_ctrl #(
      .TIMEOUT_CYCLES (T_CYC),
      .FIFO_DEPTH     (DEPTH),
      .SYNC_STAGES    (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .kbclk     (kbclk),
      .kbdata    (kbdata),
      .ev_valid  (ev_valid),
      .ev_ready  (ev_ready),
      .ev_code   (ev_code),
      .ev_ext    (ev_ext),
      .ev_break  (ev_break),
      .frame_err (frame_err),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .dbg_state (dbg_state)
   );

   // Clock and global timeout
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: observed no finish, required finish before 5ms");
      $fatal(1, "watchdog expired");
   end

   // Monitor: record accepted events and frame_err pulses, away from the edge
   always @(negedge clk) begin
      if (rst_n && ev_valid && ev_ready) got_q.push_back({ev_ext, ev_break, ev_code});
      if (rst_n && frame_err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   // Reference model: a frame is good iff parity odd and stop high
   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         ext_p = 1'b0;
         brk_p = 1'b0;
         exp_err++;
      end else if (b == 8'hE0) begin
         ext_p = 1'b1;
      end else if (b == 8'hF0) begin
         brk_p = 1'b1;
      end else begin
         exp_q.push_back({ext_p, brk_p, b});
         ext_p = 1'b0;
         brk_p = 1'b0;
      end
   endtask

   task automatic drive_bit(input logic b);
      @(posedge clk); #1 kbdata = b;
      repeat (7) @(posedge clk);
      #1 kbclk = 1'b0;
      repeat (8) @(posedge clk);
      #1 kbclk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input bit lat_chk);
      logic [10:0] bits;
      logic [5:0]  vseen;
      logic [7:0]  code4;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (lat_chk && i == 10) begin
            @(posedge clk); #1 kbdata = bits[i];
            repeat (7) @(posedge clk);
            #1 kbclk = 1'b0;
            code4 = 8'h00;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               vseen[k] = ev_valid;
               if (k == 4) code4 = ev_code;
            end
            check("latency ev_valid pattern", 32'(vseen), 32'h10);
            check("latency ev_code", 32'(code4), 32'h1C);
            @(posedge clk); #1 kbclk = 1'b1;
         end else begin
            drive_bit(bits[i]);
         end
      end
      @(posedge clk); #1 kbdata = 1'b1;
      repeat (20) @(posedge clk);
      model_frame(b, !bad_par && !bad_stop);
   endtask

   task automatic check_events(input string tag);
      int n;
      repeat (12) @(negedge clk);
      n = got_q.size() - got_base;
      check({tag, " event count"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++)
         check({tag, " event"}, 32'(got_q[got_base + i]), 32'(exp_q[i]));
      check({tag, " frame_err count"}, 32'(err_cnt - err_base), 32'(exp_err));
      got_base = got_q.size();
      err_base = err_cnt;
      exp_q.delete();
      exp_err = 0;
   endtask

   initial begin
      int  n;
      bit  seen;
      logic [7:0] rb;
      int  sel;

      rst_n = 1'b0; kbclk = 1'b1; kbdata = 1'b1; ev_ready = 1'b1; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset ev_valid", 32'(ev_valid), 32'h0);
      check("reset ev_code", 32'(ev_code), 32'h00);
      check("reset ev_ext", 32'(ev_ext), 32'h0);
      check("reset ev_break", 32'(ev_break), 32'h0);
      check("reset frame_err", 32'(frame_err), 32'h0);
      check("reset ovf", 32'(ovf), 32'h0);
      check("reset state", 32'(dbg_state), 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // Single make code with exact latency
      send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
      check_events("make 1C");

      // Break and extended break sequences
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0, 1'b0);
      check_events("prefixes");

      // Parity error clears a pending break prefix
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      send_frame(8'h32, 1'b0, 1'b0, 1'b0);
      check_events("parity error");

      // Stop-bit error
      send_frame(8'h44, 1'b0, 1'b1, 1'b0);
      check_events("stop error");

      // Timeout: stall after start + 4 data bits
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      seen = 1'b0;
      n = 0;
      while (!seen && n < T_CYC + 50) begin
         @(negedge clk);
         n++;
         if (frame_err) seen = 1'b1;
      end
      check("timeout frame_err seen", 32'(seen), 32'h1);
      check("timeout cycle in window", 32'(n >= T_CYC - 6 && n <= T_CYC - 2), 32'h1);
      @(negedge clk);
      check("timeout state idle", 32'(dbg_state), 32'h0);
      ext_p = 1'b0; brk_p = 1'b0; exp_err++;
      send_frame(8'h29, 1'b0, 1'b0, 1'b0);
      check_events("timeout");

      // Overflow: consumer stalled, five make codes
      @(posedge clk); #1 ev_ready = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
      while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
      @(negedge clk);
      check("ovf set", 32'(ovf), 32'h1);
      check("ovf head valid", 32'(ev_valid), 32'h1);
      check("ovf head code", 32'(ev_code), 32'h01);
      @(posedge clk); #1 ovf_clr = 1'b1;
      @(posedge clk); #1 ovf_clr = 1'b0;
      @(negedge clk);
      check("ovf cleared", 32'(ovf), 32'h0);
      @(posedge clk); #1 ev_ready = 1'b1;
      check_events("drain");

      // Reset mid-frame with two events queued
      @(posedge clk); #1 ev_ready = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h12, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      @(negedge clk);
      check("pre-reset ev_valid", 32'(ev_valid), 32'h1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("reset ev_valid immediate", 32'(ev_valid), 32'h0);
      check("reset state immediate", 32'(dbg_state), 32'h0);
      kbclk = 1'b1; kbdata = 1'b1;
      exp_q.delete();
      ext_p = 1'b0; brk_p = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1; ev_ready = 1'b1;
      repeat (4) @(posedge clk);
      send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
      check_events("after reset");

      // Random frames against the model
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 7);
         if (sel == 0)      rb = 8'hE0;
         else if (sel == 1) rb = 8'hF0;
         else               rb = 8'($urandom_range(0, 255));
         sel = $urandom_range(0, 9);
         send_frame(rb, sel == 0, sel == 1, 1'b0);
      end
      check_events("random");

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
